// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative signed divider.
// Widths up to 64 bits are supported by the helper functions.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH);

  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

  function automatic logic [63:0] most_neg(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/seq_udiv_core.sv
// Unsigned radix-2 restoring divider core.
// One quotient bit per clock, MSB first, WIDTH clocks per divide.
module seq_udiv_core
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_abs,
  input  logic [WIDTH-1:0] b_abs,
  output logic             done,
  output logic [WIDTH-1:0] uq,
  output logic [WIDTH-1:0] ur
);

  localparam int CW = cnt_width(WIDTH);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic             busy;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // rem < dsr keeps shifted below 2^WIDTH, so diff[WIDTH] is the sign
  assign shifted = {rem, dvd[WIDTH-1]};
  assign diff    = shifted - {1'b0, dsr};
  assign done    = busy && (cnt == CW'(WIDTH - 1));
  assign uq      = dvd;
  assign ur      = rem;

  // dvd shifts dividend bits out the top and quotient bits in the bottom
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      rem  <= '0;
      dvd  <= '0;
      dsr  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      cnt  <= '0;
      rem  <= '0;
      dvd  <= a_abs;
      dsr  <= b_abs;
      busy <= 1'b1;
    end else if (busy) begin
      if (diff[WIDTH]) begin
        rem <= shifted[WIDTH-1:0];
        dvd <= {dvd[WIDTH-2:0], 1'b0};
      end else begin
        rem <= diff[WIDTH-1:0];
        dvd <= {dvd[WIDTH-2:0], 1'b1};
      end
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Iterative signed divider: sign/abs pre-processing, handshake FSM
// and sign/special-case fix-up around the unsigned restoring core.
module seq_signed_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             valid_out,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] MNEG = WIDTH'(most_neg(WIDTH));

  state_t           state;
  logic             accept;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] mag_a;
  logic             sign_q;
  logic             sign_r;
  logic             zero_f;
  logic             ovf_f;
  logic             done;
  logic [WIDTH-1:0] uq;
  logic [WIDTH-1:0] ur;

  assign accept = valid_in && ready_out;
  assign abs_a  = A[WIDTH-1] ? -A : A;
  assign abs_b  = B[WIDTH-1] ? -B : B;

  seq_udiv_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk  (clk),
    .rst_n(rst_n),
    .start(accept),
    .a_abs(abs_a),
    .b_abs(abs_b),
    .done (done),
    .uq   (uq),
    .ur   (ur)
  );

  // Handshake FSM; all outputs registered, results applied in FIX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ready_out   <= 1'b1;
      valid_out   <= 1'b0;
      Q           <= '0;
      R           <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      mag_a       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      zero_f      <= 1'b0;
      ovf_f       <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            state     <= CALC;
            ready_out <= 1'b0;
            mag_a     <= abs_a;
            sign_q    <= A[WIDTH-1] ^ B[WIDTH-1];
            sign_r    <= A[WIDTH-1];
            zero_f    <= (B == '0);
            ovf_f     <= (A == MNEG) && (B == '1);
          end
        end
        CALC: begin
          if (done) state <= FIX;
        end
        FIX: begin
          state     <= IDLE;
          ready_out <= 1'b1;
          valid_out <= 1'b1;
          if (zero_f) begin
            Q           <= '1;
            R           <= sign_r ? -mag_a : mag_a;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else if (ovf_f) begin
            Q           <= MNEG;
            R           <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b1;
          end else begin
            Q           <= sign_q ? -uq : uq;
            R           <= sign_r ? -ur : ur;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          ready_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed-vector bench for seq_signed_divider (WIDTH = 32).
// Expected quotients/remainders are hand-computed constants.
module tb_seq_signed_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        ready_out;
  logic        valid_out;
  logic [31:0] Q;
  logic [31:0] R;
  logic        div_by_zero;
  logic        overflow;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ov;
  } vec_t;

  vec_t vecs[] = '{
    '{"p_p",    32'd100,        32'd7,          32'd14,
      32'd2,          1'b0, 1'b0},
    '{"n_p",    32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,
      32'hFFFFFFFE,   1'b0, 1'b0},
    '{"p_n",    32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,
      32'd2,          1'b0, 1'b0},
    '{"n_n",    32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,
      32'hFFFFFFFE,   1'b0, 1'b0},
    '{"dz_p",   32'd5,          32'd0,          32'hFFFFFFFF,
      32'd5,          1'b1, 1'b0},
    '{"ovf",    32'h80000000,   32'hFFFFFFFF,   32'h80000000,
      32'd0,          1'b0, 1'b1},
    '{"dz_n",   32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,
      32'hFFFFFFF9,   1'b1, 1'b0},
    '{"dz_mn",  32'h80000000,   32'd0,          32'hFFFFFFFF,
      32'h80000000,   1'b1, 1'b0},
    '{"a_zero", 32'd0,          32'hFFFFFFFB,   32'd0,
      32'd0,          1'b0, 1'b0},
    '{"small",  32'hFFFFFFFD,   32'd7,          32'd0,
      32'hFFFFFFFD,   1'b0, 1'b0},
    '{"b_m1",   32'd7,          32'hFFFFFFFF,   32'hFFFFFFF9,
      32'd0,          1'b0, 1'b0},
    '{"max_m1", 32'h7FFFFFFF,   32'hFFFFFFFF,   32'h80000001,
      32'd0,          1'b0, 1'b0},
    '{"mn_1",   32'h80000000,   32'd1,          32'h80000000,
      32'd0,          1'b0, 1'b0},
    '{"mn_2",   32'h80000000,   32'd2,          32'hC0000000,
      32'd0,          1'b0, 1'b0},
    '{"mn_3",   32'h80000000,   32'd3,          32'hD5555556,
      32'hFFFFFFFE,   1'b0, 1'b0},
    '{"one_mn", 32'd1,          32'h80000000,   32'd0,
      32'd1,          1'b0, 1'b0},
    '{"mn_mn",  32'h80000000,   32'h80000000,   32'd1,
      32'd0,          1'b0, 1'b0}
  };

  seq_signed_divider #(
    .WIDTH(32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .A          (A),
    .B          (B),
    .valid_out  (valid_out),
    .Q          (Q),
    .R          (R),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    @(negedge clk);
    check({v.tag, "_rdy_in"}, ready_out, 1);
    A = v.a;
    B = v.b;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    check({v.tag, "_busy"}, ready_out, 0);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!valid_out && n < 100);
    check({v.tag, "_lat"}, n, 33);
    check({v.tag, "_q"}, Q, v.q);
    check({v.tag, "_r"}, R, v.r);
    check({v.tag, "_dz"}, div_by_zero, v.dz);
    check({v.tag, "_ov"}, overflow, v.ov);
    check({v.tag, "_rdy"}, ready_out, 1);
    @(posedge clk);
    #1;
    check({v.tag, "_pulse"}, valid_out, 0);
  endtask

  initial begin
    int m;
    int pulses;
    vec_t post;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", ready_out, 1);
    check("rst_vld", valid_out, 0);
    check("rst_q", Q, 0);
    check("rst_r", R, 0);
    check("rst_dz", div_by_zero, 0);
    check("rst_ov", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // busy: second pair held on valid_in throughout the first divide
    @(negedge clk);
    A = 32'd50;
    B = 32'd3;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    A = 32'd9;
    B = 32'd2;
    m = 0;
    do begin
      @(posedge clk);
      #1;
      m++;
    end while (!valid_out && m < 100);
    check("bsy1_lat", m, 33);
    check("bsy1_q", Q, 16);
    check("bsy1_r", R, 2);
    check("bsy1_rdy", ready_out, 1);
    m = 0;
    do begin
      @(posedge clk);
      #1;
      m++;
      if (m == 1) valid_in = 1'b0;
    end while (!valid_out && m < 100);
    check("bsy2_gap", m, 34);
    check("bsy2_q", Q, 4);
    check("bsy2_r", R, 1);

    // reset during an active divide
    @(negedge clk);
    A = 32'd1000;
    B = 32'd10;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    repeat (10) @(posedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_q", Q, 0);
    check("abort_r", R, 0);
    check("abort_vld", valid_out, 0);
    check("abort_rdy", ready_out, 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_rdy2", ready_out, 1);
    pulses = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (valid_out) pulses++;
    end
    check("abort_nopulse", pulses, 0);

    post = '{"post", 32'd1000, 32'd10, 32'd100,
             32'd0, 1'b0, 1'b0};
    run_vec(post);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_signed_divider.md
Name: seq_signed_divider

Overview:
Iterative signed integer divider. It computes quotient and remainder of two WIDTH-bit two's-complement operands using radix-2 restoring division, one quotient bit per clock. It is the inverse-arithmetic companion to the pipelined signed multiplier in the NPU processing element, and it serves normalisation/averaging paths that need A/B. It uses the same valid-style handshake as the multiplier, plus a ready signal, because the divider is not fully pipelined.

Parameters:
WIDTH, 32, operand width in bits; also the result width. Must be >= 4.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous, active-low reset
valid_in  input  1  operands present on A/B this cycle
ready_out  output  1  divider can accept an operand pair this cycle
A  input  WIDTH  signed dividend
B  input  WIDTH  signed divisor
valid_out  output  1  one-cycle pulse; Q/R/flags valid
Q  output  WIDTH  signed quotient, truncated toward zero
R  output  WIDTH  signed remainder; sign follows dividend
div_by_zero  output  1  result produced with B == 0
overflow  output  1  result produced for most-negative / -1

Behaviour:
- Reset (async assert, sync deassert):
  - state = IDLE; ready_out = 1; valid_out = 0.
  - Q, R, div_by_zero and overflow = 0.
  - Reset asserted mid-calculation aborts the operation. No valid_out is produced for the aborted request.
- Accept: a request is taken when valid_in && ready_out at a rising edge (edge E0). A and B are sampled only at E0. valid_in while ready_out = 0 is ignored (dropped, not queued).
- FSM:
  - IDLE: ready_out = 1. On accept, go to CALC and latch the following:
    - |A| and |B| as WIDTH-bit unsigned values. |most-negative| = 2^(WIDTH-1) fits in WIDTH unsigned bits.
    - sign_q = A[msb] ^ B[msb].
    - sign_r = A[msb].
    - zero flag = (B == 0).
    - ovf flag = (A == most-negative && B == -1).
    - Clear the iteration counter and the partial remainder.
  - CALC: ready_out = 0. Run exactly WIDTH iterations on edges E0+1 .. E0+WIDTH.
    - Each iteration shifts the partial remainder (WIDTH+1 bits) left by one and brings in the next dividend bit, MSB first.
    - It trial-subtracts |B|. If the result is non-negative, it keeps the difference and the quotient bit is 1; otherwise it restores and the bit is 0.
    - The counter runs 0..WIDTH-1. Leave CALC when counter == WIDTH-1.
  - FIX: ready_out = 0. At edge E0+WIDTH+1, register the outputs, pulse valid_out, and return to IDLE:
    - Q = sign_q ? -uq : uq.
    - R = sign_r ? -ur : ur.
- Latency: valid_out is high in the cycle after edge E0+WIDTH+1, which is WIDTH+1 edges after accept. For WIDTH = 32 that is 33. Latency is fixed and does not depend on the data, including the special cases.
- ready_out returns high in the same cycle that valid_out is high. A new request may be accepted at the edge that ends the valid_out cycle, giving a throughput of one result per WIDTH+2 cycles.
- Q, R and the flags hold their values until the next FIX. valid_out is high for exactly one cycle per accepted request.
- Special cases, resolved in FIX; the iteration still runs and its result is overridden:
  - B == 0: Q = all ones (-1), R = A, div_by_zero = 1, overflow = 0.
  - A = most-negative, B = -1: Q = most-negative (wrap), R = 0, overflow = 1, div_by_zero = 0.
  - Otherwise both flags are 0. Flags describe only the current result.
- Invariant for non-special cases:
  - A == Q*B + R.
  - |R| < |B|.
  - R == 0, or sign(R) == sign(A).

Decomposition:
- Package div_pkg holds:
  - the state enum (IDLE, CALC, FIX);
  - the localparam for the counter width, $clog2(WIDTH);
  - a function computing the most-negative WIDTH-bit constant.
- Sub-module seq_udiv_core is the unsigned restoring core. It has start, |A|, |B|, done, uq and ur, plus the counter and partial-remainder registers.
- The top level holds the handshake, the sign/abs pre-processing, the FSM and the FIX stage.

Test Plan:
- A = 100, B = 7 -> after 33 edges, valid_out = 1 for one cycle; Q = 14, R = 2; both flags 0; ready_out = 1 in the same cycle.
- Sign combinations:
  - A = -100, B = 7 -> Q = -14, R = -2.
  - A = 100, B = -7 -> Q = -14, R = 2.
  - A = -100, B = -7 -> Q = 14, R = -2.
- A = 5, B = 0 -> Q = 0xFFFFFFFF, R = 5, div_by_zero = 1. A = 0x80000000, B = 0xFFFFFFFF -> Q = 0x80000000, R = 0, overflow = 1. Both have latency 33.
- Busy behaviour: accept A = 50, B = 3, then hold valid_in = 1 with A = 9, B = 2 throughout CALC.
  - Second pair ignored until ready_out = 1.
  - First result is Q = 16, R = 2.
  - With valid_in still high, the second pair is accepted at the next edge; its result is Q = 4, R = 1, 34 cycles after the first pulse.
- Reset mid-op: accept 1000/10, assert rst_n low at edge E0+10 -> all outputs are 0 immediately, ready_out = 1 after deassert, and no valid_out ever appears for that request.
- Random regression: 10k random signed pairs, including B = ±1, A = 0, |A| < |B| and most-negative operands -> every result matches the reference model (truncating division plus the special-case rules); exactly one valid_out per accept.
